// File: rtl/ccc_cfg_pkg.sv
// Shared types for the CCC/PLL dynamic-reconfiguration sequencer:
// FSM encoding, error causes, pass flag and APB bus widths.
package ccc_cfg_pkg;

   localparam int APB_AW = 6;
   localparam int APB_DW = 8;
   localparam int TMR_W  = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST_PLL,
      ST_FETCH,
      ST_WAIT_BUSY,
      ST_SETUP,
      ST_ACCESS,
      ST_RELEASE,
      ST_WAIT_LOCK,
      ST_DONE,
      ST_ERROR
   } state_e;

   typedef enum logic [1:0] {
      ERR_BUSY_TMO  = 2'b00,
      ERR_VERIFY    = 2'b01,
      ERR_LOCK_TMO  = 2'b10,
      ERR_LOCK_LOST = 2'b11
   } err_code_e;

   typedef enum logic {
      PASS_WR = 1'b0,
      PASS_VF = 1'b1
   } pass_e;

   function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
      return (t == '1) ? t : t + TMR_W'(1);
   endfunction

endpackage

// File: rtl/ccc_reconfig_ctrl_if.sv
// Sequencer-side view of the CCC APB port, the config ROM and the CCC status pins.
// The sequencer is the master; the CCC/ROM side is the slave.
interface ccc_reconfig_ctrl_if;
   import ccc_cfg_pkg::*;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [APB_AW-1:0] paddr;
   logic [APB_DW-1:0] pwdata;
   logic [APB_DW-1:0] prdata;
   logic [APB_AW-1:0] cfg_raddr;
   logic [APB_DW-1:0] cfg_rdata;
   logic              ccc_busy;
   logic              ccc_lock;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, cfg_raddr,
      input  prdata, cfg_rdata, ccc_busy, ccc_lock
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, cfg_raddr,
      output prdata, cfg_rdata, ccc_busy, ccc_lock
   );

endinterface

// File: rtl/ccc_lock_filter.sv
// 2-flop synchronizer plus saturating run counter for the async CCC LOCK pin.
// stable_o is high in the LOCK_STABLE-th consecutive synchronized-high cycle onwards.
module ccc_lock_filter #(
   parameter int LOCK_STABLE = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic lock_i,
   input  logic clr_i,
   output logic lock_sync_o,
   output logic stable_o
);

   localparam int CW = $clog2(LOCK_STABLE + 1);
   localparam logic [CW-1:0] STB    = CW'(LOCK_STABLE);
   localparam logic [CW-1:0] STB_M1 = CW'(LOCK_STABLE - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], lock_i};
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != STB) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // The current high cycle counts, so the run is complete one count early.
   assign lock_sync_o = sync_q[1];
   assign stable_o    = sync_q[1] && (cnt_q >= STB_M1);

endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// Reprograms the CCC/PLL over its APB reconfig port: hold reset, write + verify all bytes, wait for lock.
// Each byte costs 5 cycles with no BUSY stall; BUSY and LOCK decisions lag their pins by 2 cycles.
module ccc_reconfig_ctrl
   import ccc_cfg_pkg::*;
#(
   parameter int NUM_REGS     = 27,
   parameter int RST_HOLD     = 8,
   parameter int BUSY_TIMEOUT = 1024,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int LOCK_STABLE  = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   ccc_reconfig_ctrl_if.master bus,
   output logic                pll_arst_n_o,
   output logic                pll_powerdown_n_o,
   output logic                ctrl_busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [1:0]          err_code_o,
   output logic                locked_o
);

   localparam logic [APB_AW-1:0] LAST_IDX = APB_AW'(NUM_REGS - 1);
   localparam logic [TMR_W-1:0]  HOLD_M1  = TMR_W'(RST_HOLD - 1);
   localparam logic [TMR_W-1:0]  BUSY_M1  = TMR_W'(BUSY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  LOCK_M1  = TMR_W'(LOCK_TIMEOUT - 1);

   state_e            state_q, state_d;
   pass_e             pass_q, pass_d;
   err_code_e         err_code_q, err_code_d;
   logic [APB_AW-1:0] idx_q, idx_d;
   logic [APB_DW-1:0] wdat_q, wdat_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              fph_q, fph_d;
   logic              pll_arst_n_q, pll_arst_n_d;
   logic              done_q, done_d;
   logic              locked_q, locked_d;
   logic [1:0]        busy_sync_q;
   logic              busy_s;
   logic              lock_s;
   logic              lock_stable;
   logic              go;
   logic              apb_sel;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_sync_q <= '0;
      end else begin
         busy_sync_q <= {busy_sync_q[0], bus.ccc_busy};
      end
   end
   assign busy_s = busy_sync_q[1];

   ccc_lock_filter #(
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_filter (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .lock_i      (bus.ccc_lock),
      .clr_i       (state_q == ST_RELEASE),
      .lock_sync_o (lock_s),
      .stable_o    (lock_stable)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         pass_q       <= PASS_WR;
         err_code_q   <= ERR_BUSY_TMO;
         idx_q        <= '0;
         wdat_q       <= '0;
         tmr_q        <= '0;
         fph_q        <= 1'b0;
         pll_arst_n_q <= 1'b1;
         done_q       <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pass_q       <= pass_d;
         err_code_q   <= err_code_d;
         idx_q        <= idx_d;
         wdat_q       <= wdat_d;
         tmr_q        <= tmr_d;
         fph_q        <= fph_d;
         pll_arst_n_q <= pll_arst_n_d;
         done_q       <= done_d;
         locked_q     <= locked_d;
      end
   end

   // START is dead in the DONE-pulse cycle so a late request cannot cut the pulse short.
   assign go = start_i && ((state_q == ST_IDLE) || (state_q == ST_ERROR) ||
                           ((state_q == ST_DONE) && !done_q));

   always_comb begin
      state_d      = state_q;
      pass_d       = pass_q;
      err_code_d   = err_code_q;
      idx_d        = idx_q;
      wdat_d       = wdat_q;
      tmr_d        = '0;
      fph_d        = 1'b0;
      pll_arst_n_d = pll_arst_n_q;
      done_d       = 1'b0;
      locked_d     = locked_q;

      case (state_q)
         ST_RST_PLL: begin
            tmr_d = tmr_inc(tmr_q);
            if (tmr_q >= HOLD_M1) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // Phase 0 presents the ROM address, phase 1 captures the registered ROM data.
            if (!fph_q) begin
               fph_d = 1'b1;
            end else begin
               wdat_d  = bus.cfg_rdata;
               state_d = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            tmr_d = tmr_inc(tmr_q);
            if (!busy_s) begin
               state_d = ST_SETUP;
            end else if (tmr_q >= BUSY_M1) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_BUSY_TMO;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if ((pass_q == PASS_VF) && (bus.prdata != wdat_q)) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_VERIFY;
            end else if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (pass_q == PASS_WR) begin
                  pass_d  = PASS_VF;
                  state_d = ST_FETCH;
               end else begin
                  pll_arst_n_d = 1'b1;
                  state_d      = ST_RELEASE;
               end
            end else begin
               idx_d   = idx_q + APB_AW'(1);
               state_d = ST_FETCH;
            end
         end
         ST_RELEASE: begin
            state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            tmr_d = tmr_inc(tmr_q);
            if (lock_stable) begin
               locked_d = 1'b1;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end else if (tmr_q >= LOCK_M1) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_LOCK_TMO;
            end
         end
         ST_DONE: begin
            if (!lock_s) begin
               locked_d   = 1'b0;
               state_d    = ST_ERROR;
               err_code_d = ERR_LOCK_LOST;
            end
         end
         ST_IDLE, ST_ERROR: begin
            state_d = state_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (go) begin
         state_d      = ST_RST_PLL;
         pass_d       = PASS_WR;
         idx_d        = '0;
         tmr_d        = '0;
         pll_arst_n_d = 1'b0;
         locked_d     = 1'b0;
         err_code_d   = ERR_BUSY_TMO;
      end
   end

   assign apb_sel       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign bus.psel      = apb_sel;
   assign bus.penable   = (state_q == ST_ACCESS);
   assign bus.pwrite    = apb_sel && (pass_q == PASS_WR);
   assign bus.paddr     = apb_sel ? idx_q : '0;
   assign bus.pwdata    = apb_sel ? wdat_q : '0;
   assign bus.cfg_raddr = idx_q;

   assign pll_arst_n_o      = pll_arst_n_q;
   assign pll_powerdown_n_o = 1'b1;
   assign ctrl_busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
   assign done_o            = done_q;
   assign err_o             = (state_q == ST_ERROR);
   assign err_code_o        = err_code_q;
   assign locked_o          = locked_q;

endmodule
